// File: rtl/vedic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : vedic_pkg
// Brief  : Shared widths and partial-product ordering for the Vedic multiplier.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package vedic_pkg;

  localparam int PP_W   = 8;
  localparam int PROD_W = 16;

  // Partial-product order shared with the 4x4 multiplier stage.
  typedef enum logic [1:0] {
    PP_LL = 2'd0,
    PP_HL = 2'd1,
    PP_LH = 2'd2,
    PP_HH = 2'd3
  } pp_idx_e;

  typedef struct packed {
    logic [PP_W:0]   mid;
    logic [PP_W-1:0] q0;
    logic [PP_W-1:0] q3;
  } s1_data_t;

endpackage
`default_nettype wire

// File: rtl/vedic8_pp_combine_pipe_adders.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : full_adder / four_bit_ripple_adder / adder12_ripple
// Brief  : Ripple-carry adder building blocks for the combine stage.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module four_bit_ripple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] w_c;

  assign w_c[0] = cin;
  assign cout   = w_c[4];

  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_c[i]),
      .sum (sum[i]),
      .cout(w_c[i+1])
    );
  end
endmodule

module adder12_ripple (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] sum,
  output logic        cout
);
  logic [3:0] w_c;

  assign w_c[0] = 1'b0;
  assign cout   = w_c[3];

  for (genvar n = 0; n < 3; n++) begin : g_nib
    logic w_co;
    four_bit_ripple_adder u_add4 (
      .a   (a[4*n +: 4]),
      .b   (b[4*n +: 4]),
      .cin (w_c[n]),
      .sum (sum[4*n +: 4]),
      .cout(w_co)
    );
    if (n < 2) begin : g_link
      assign w_c[n+1] = w_co;
    end else begin : g_last
      assign w_c[3] = w_co;
    end
  end
endmodule
`default_nettype wire

// File: rtl/vedic8_pp_combine_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : vedic8_pp_combine_pipe
// Brief  : Two-stage valid/ready pipeline reducing q0..q3 to the 16-bit product.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module vedic8_pp_combine_pipe
  import vedic_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PP_W-1:0]   q0,
  input  logic [PP_W-1:0]   q1,
  input  logic [PP_W-1:0]   q2,
  input  logic [PP_W-1:0]   q3,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  logic              r_v1;
  logic              r_v2;
  s1_data_t          r_s1;
  logic [TAG_W-1:0]  r_tag1;
  logic [TAG_W-1:0]  r_tag2;
  logic [PROD_W-1:0] r_product;

  logic              w_en1;
  logic              w_en2;
  logic              w_mid_c;
  logic              w_mid_co;
  logic [PP_W:0]     w_mid;
  logic [11:0]       w_upper;
  logic              w_carry_unused;

  // A stage may load whenever it is empty or its contents move on this cycle.
  assign w_en2    = !r_v2 | out_ready;
  assign w_en1    = !r_v1 | w_en2;
  assign in_ready = w_en1;

  four_bit_ripple_adder u_mid_lo (
    .a   (q1[3:0]),
    .b   (q2[3:0]),
    .cin (1'b0),
    .sum (w_mid[3:0]),
    .cout(w_mid_c)
  );

  four_bit_ripple_adder u_mid_hi (
    .a   (q1[7:4]),
    .b   (q2[7:4]),
    .cin (w_mid_c),
    .sum (w_mid[7:4]),
    .cout(w_mid_co)
  );

  assign w_mid[8] = w_mid_co;

  // Upper 12 bits: {q3, q0[7:4]} + mid; the true sum never exceeds 0xFFF.
  adder12_ripple u_upper (
    .a   ({r_s1.q3, r_s1.q0[7:4]}),
    .b   ({3'b000, r_s1.mid}),
    .sum (w_upper),
    .cout(w_carry_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_s1      <= '0;
      r_tag1    <= '0;
      r_tag2    <= '0;
      r_product <= '0;
    end else begin
      if (w_en1) begin
        r_v1    <= in_valid;
        r_s1    <= '{mid: w_mid, q0: q0, q3: q3};
        r_tag1  <= in_tag;
      end
      if (w_en2) begin
        r_v2      <= r_v1;
        r_product <= {w_upper, r_s1.q0[3:0]};
        r_tag2    <= r_tag1;
      end
    end
  end

  assign out_valid = r_v2;
  assign product   = r_product;
  assign out_tag   = r_tag2;
  assign busy      = r_v1 | r_v2;

endmodule
`default_nettype wire
